// File: rtl/mips_regfile_pkg.sv
// Shared widths and register-name constants for the register file, its
// bench and the control unit.
package mips_regfile_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] R_SP     = 5'd29;
    localparam logic [REG_ADDR_W-1:0] R_RA     = 5'd31;

endpackage : mips_regfile_pkg

// File: rtl/mips_regfile_reg32.sv
// Single architectural register: WIDTH-bit D register with load enable and
// asynchronous active-low clear.
module mips_regfile_reg32
    import mips_regfile_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d on enabled edges; clear immediately when reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: architectural registers must read zero during reset, so every
        // storage bit takes the async clear rather than being left unreset.
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            // NOTE: non-blocking so all 31 registers sample the same edge
            // without ordering races between instances.
            q <= d;
        end
    end

endmodule : mips_regfile_reg32

// File: rtl/mips_regfile.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one write
// port, r0 hard-wired to zero, optional same-cycle write-to-read bypass.
module mips_regfile
    import mips_regfile_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]  WD,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    wire  [ADDR_W-1:0] wa_n;
    wire  [DEPTH-1:1]  wr_dec;   // one-hot write strobes; r0 has none
    logic [WIDTH-1:0]  rd1_raw;
    logic [WIDTH-1:0]  rd2_raw;

    // Inverted write-address literals for the decoder AND chains.
    for (genvar b = 0; b < ADDR_W; b++) begin : g_wa_inv
        not u_inv (wa_n[b], WA[b]);
    end

    // One-hot write decode gated by RegWrite: each strobe is an AND chain of
    // RegWrite and the true/complement address bits matching its index.
    for (genvar i = 1; i < DEPTH; i++) begin : g_dec
        wire [ADDR_W:0] chain;
        buf u_en (chain[0], RegWrite);
        for (genvar b = 0; b < ADDR_W; b++) begin : g_bit
            if (((i >> b) & 1) == 1) begin : g_one
                and u_and (chain[b+1], chain[b], WA[b]);
            end else begin : g_zero
                and u_and (chain[b+1], chain[b], wa_n[b]);
            end
        end
        buf u_out (wr_dec[i], chain[ADDR_W]);
    end

    // r0 is a constant; r1..r31 are real registers.
    assign regs[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_reg
        mips_regfile_reg32 #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (wr_dec[i]),
            .d     (WD),
            .q     (regs[i])
        );
    end

    // Two 32:1 read muxes over the stored values (r0 reads the constant).
    always_comb begin
        rd1_raw = regs[RA1];
        rd2_raw = regs[RA2];
    end

    if (BYPASS) begin : g_bypass
        // A live write to a nonzero register is forwarded; held reset or an
        // X/Z enable suppresses forwarding so reads stay at zero/stored value.
        logic byp_en;
        assign byp_en = rst_n & RegWrite & (WA != '0);

        // Bypass 2:1 muxes: same-cycle write data wins over the stored value.
        always_comb begin
            // NOTE: defaults first so every path assigns both outputs and no
            // latch is inferred.
            RD1 = rd1_raw;
            RD2 = rd2_raw;
            if (byp_en && (RA1 == WA)) RD1 = WD;
            if (byp_en && (RA2 == WA)) RD2 = WD;
        end
    end else begin : g_no_bypass
        assign RD1 = rd1_raw;
        assign RD2 = rd2_raw;
    end

endmodule : mips_regfile

// File: tb/tb_mips_regfile.sv
// Scoreboard bench for mips_regfile: one bypassing and one non-bypassing
// instance share stimulus; expected reads come from an array model.
module tb_mips_regfile;
    import mips_regfile_pkg::*;

    localparam int W = DATA_W;
    localparam int A = REG_ADDR_W;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         RegWrite = 1'b0;
    logic [A-1:0] WA       = '0;
    logic [W-1:0] WD       = '0;
    logic [A-1:0] RA1      = '0;
    logic [A-1:0] RA2      = '0;
    logic [W-1:0] rd1_b, rd2_b, rd1_n, rd2_n;

    mips_regfile #(.WIDTH(W), .ADDR_W(A), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WA(WA), .WD(WD),
        .RA1(RA1), .RA2(RA2), .RD1(rd1_b), .RD2(rd2_b)
    );

    mips_regfile #(.WIDTH(W), .ADDR_W(A), .BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WA(WA), .WD(WD),
        .RA1(RA1), .RA2(RA2), .RD1(rd1_n), .RD2(rd2_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] e1b, e2b, e1n, e2n;
        bit           alu;
        logic [W-1:0] alu_exp;
    } exp_t;

    exp_t         exp_q[$];
    event         ev_push;
    logic [W-1:0] model [2**A];
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural read rule: r0 and held reset read zero; a live write to
    // the same register is seen only when bypassing; else the stored value.
    function automatic logic [W-1:0] ref_read(input logic [A-1:0] ra, input bit bypass);
        if (!rst_n || ra == REG_ZERO) return '0;
        if (bypass && RegWrite === 1'b1 && WA == ra) return WD;
        return model[ra];
    endfunction

    // Apply inputs, let reads settle, queue the expected responses.
    task automatic drive(input string name, input bit we, input logic [A-1:0] wa,
                         input logic [W-1:0] wd, input logic [A-1:0] ra1,
                         input logic [A-1:0] ra2, input bit alu = 1'b0,
                         input logic [W-1:0] alu_exp = '0);
        exp_t e;
        RegWrite = we; WA = wa; WD = wd; RA1 = ra1; RA2 = ra2;
        #1;
        e.name    = name;
        e.e1b     = ref_read(ra1, 1'b1);
        e.e2b     = ref_read(ra2, 1'b1);
        e.e1n     = ref_read(ra1, 1'b0);
        e.e2n     = ref_read(ra2, 1'b0);
        e.alu     = alu;
        e.alu_exp = alu_exp;
        exp_q.push_back(e);
        -> ev_push;
        #1;
    endtask

    // Advance one clock; the model commits a write only when reset is off.
    task automatic tick();
        @(posedge clk);
        if (rst_n && RegWrite === 1'b1 && WA != REG_ZERO) model[WA] = WD;
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2**A; i++) model[i] = '0;
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(ev_push);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, " rd1"},    rd1_b, e.e1b);
                check({e.name, " rd2"},    rd2_b, e.e2b);
                check({e.name, " nb rd1"}, rd1_n, e.e1n);
                check({e.name, " nb rd2"}, rd2_n, e.e2n);
                if (e.alu) check({e.name, " and"}, rd1_b & rd2_b, e.alu_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        @(negedge clk);
        drive("reset_hold", 1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill r1..r31, checking same-cycle bypass, then read everything back.
        for (int i = 1; i < 32; i++) begin
            drive($sformatf("wr_r%0d", i), 1'b1, A'(i), 32'hA5A5_0000 + W'(i), A'(i), A'(i));
            tick();
        end
        for (int i = 1; i < 32; i++) begin
            drive($sformatf("rd_r%0d", i), 1'b0, '0, '0, A'(i), A'(32 - i));
            tick();
        end
        drive("rd_ra", 1'b0, '0, '0, R_RA, R_SP);
        tick();

        // Writes to r0 are discarded.
        drive("zero_wr", 1'b1, REG_ZERO, 32'hFFFF_FFFF, REG_ZERO, REG_ZERO);
        tick();
        drive("zero_rd", 1'b0, '0, '0, REG_ZERO, REG_ZERO);
        tick();

        // Bypass vs stored value around the edge.
        drive("byp_seed", 1'b1, 5'd5, 32'h1111_1111, 5'd4, 5'd6);
        tick();
        drive("byp_pre", 1'b1, 5'd5, 32'h2222_2222, 5'd5, 5'd5);
        tick();
        drive("byp_post", 1'b0, '0, '0, 5'd5, 5'd5);
        tick();

        // Operands feeding an ALU AND.
        drive("alu_w8", 1'b1, 5'd8, 32'hF0F0_F0F0, 5'd0, 5'd0);
        tick();
        drive("alu_w9", 1'b1, 5'd9, 32'h0FF0_0FF0, 5'd8, 5'd0);
        tick();
        drive("alu_and", 1'b0, '0, '0, 5'd8, 5'd9, 1'b1, 32'h00F0_00F0);
        tick();

        // Random traffic, biased towards read/write address collisions.
        for (int n = 0; n < 300; n++) begin
            logic [A-1:0] wa;
            wa = A'($urandom);
            drive($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), wa, $urandom,
                  ($urandom_range(0, 2) == 0) ? wa : A'($urandom),
                  ($urandom_range(0, 2) == 0) ? wa : A'($urandom));
            tick();
        end

        // Mid-cycle reset: every register reads zero before any clock edge.
        for (int i = 1; i < 32; i++) begin
            drive($sformatf("refill%0d", i), 1'b1, A'(i), $urandom | 32'h1, 5'd0, 5'd0);
            tick();
        end
        #2;
        rst_n = 1'b0;
        clear_model();
        for (int i = 0; i < 32; i++)
            drive($sformatf("rst_rd%0d", i), 1'b0, '0, '0, A'(i), A'(31 - i));
        @(negedge clk);
        rst_n = 1'b1;

        // A write across a posedge held in reset is lost.
        drive("rvw_seed", 1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0);
        tick();
        rst_n = 1'b0;
        clear_model();
        drive("rvw_hold", 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
        tick();
        rst_n = 1'b1;
        drive("rvw_after", 1'b0, '0, '0, 5'd7, 5'd7);
        tick();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) #1;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mips_regfile
